// File: rtl/marbuf_dispatch_pkg.sv
// Shared types for the marbuf dispatch stage: opcodes, FSM states
// and instruction word field positions.
package marbuf_dispatch_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_DIRECT = 2'b01,
    OP_HALT   = 2'b10,
    OP_RSVD   = 2'b11
  } opc_e;

  typedef enum logic {
    ST_HALTED = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 30;
  localparam int IDX_MSB  = 29;
  localparam int IDX_LSB  = 24;
  localparam int RSV_BIT  = 23;
  localparam int DLY_MSB  = 22;
  localparam int DLY_LSB  = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

endpackage

// File: rtl/marbuf_dispatch.sv
// Dispatch stage: decodes instruction words into per-channel buffer strobes.
// MARBUF_DISPATCH_STALL_CNT_EN enables the saturating stall-cycle counter.
module marbuf_dispatch
  import marbuf_dispatch_pkg::*;
#(
  parameter int N_BUF = 8,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic             start_i,
  input  logic             clr_err_i,
  input  logic [N_BUF-1:0] buf_full_i,
  output logic [15:0]      data_o,
  output logic [6:0]       delay_o,
  output logic [N_BUF-1:0] valid_o,
  output logic [N_BUF-1:0] direct_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [15:0]      stall_cnt_o
);

  state_e state_q, state_d;

  logic [31:0]      hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [15:0]      data_q, data_d;
  logic [6:0]       delay_q, delay_d;
  logic [N_BUF-1:0] valid_q, valid_d;
  logic [N_BUF-1:0] direct_q, direct_d;
  logic             err_q, err_d;

  opc_e             opc;
  logic [IDX_W-1:0] idx;
  logic [6:0]       dly;
  logic [15:0]      dat;
  logic             idx_ok;
  logic [63:0]      full_ext;
  logic [N_BUF-1:0] onehot;

  logic run;
  logic issue_wr;
  logic issue_dir;
  logic issue;
  logic halt_take;
  logic drop;
  logic stall;
  logic accept;
  logic unused_rsv;

  assign opc = opc_e'(hold_q[OPC_MSB:OPC_LSB]);
  assign idx = hold_q[IDX_MSB:IDX_LSB];
  assign dly = hold_q[DLY_MSB:DLY_LSB];
  assign dat = hold_q[DATA_MSB:DATA_LSB];

  assign unused_rsv = hold_q[RSV_BIT];

  assign idx_ok = ({1'b0, idx} < (IDX_W+1)'(N_BUF));
  assign onehot = {{(N_BUF-1){1'b0}}, 1'b1} << idx;

  // Zero-extended so any 6-bit index is a legal read.
  always_comb begin
    full_ext = '0;
    full_ext[N_BUF-1:0] = buf_full_i;
  end

  assign run = (state_q == ST_RUN);

  always_comb begin
    issue_wr  = 1'b0;
    issue_dir = 1'b0;
    halt_take = 1'b0;
    drop      = 1'b0;
    stall     = 1'b0;
    if (run && hold_v_q) begin
      unique case (opc)
        OP_WRITE: begin
          if (!idx_ok)
            drop = 1'b1;
          else if (full_ext[idx])
            stall = 1'b1;
          else
            issue_wr = 1'b1;
        end
        OP_DIRECT: begin
          if (!idx_ok)
            drop = 1'b1;
          else
            issue_dir = 1'b1;
        end
        OP_HALT: halt_take = 1'b1;
        OP_RSVD: drop = 1'b1;
      endcase
    end
  end

  assign issue = issue_wr | issue_dir;

  assign instr_ready_o = run && (!hold_v_q || issue);
  assign accept = instr_valid_i && instr_ready_o;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALTED: if (start_i) state_d = ST_RUN;
      ST_RUN:    if (halt_take) state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    if (issue || halt_take || drop)
      hold_v_d = 1'b0;
    if (accept) begin
      hold_d   = instr_i;
      hold_v_d = 1'b1;
    end
  end

  always_comb begin
    data_d   = data_q;
    delay_d  = delay_q;
    valid_d  = issue_wr ? onehot : '0;
    direct_d = issue_dir ? onehot : '0;
    if (issue) begin
      data_d  = dat;
      delay_d = dly;
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (clr_err_i) err_d = 1'b0;
    if (drop)      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HALTED;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      data_q   <= '0;
      delay_q  <= '0;
      valid_q  <= '0;
      direct_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      data_q   <= data_d;
      delay_q  <= delay_d;
      valid_q  <= valid_d;
      direct_q <= direct_d;
      err_q    <= err_d;
    end
  end

`ifdef MARBUF_DISPATCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (stall && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_cnt_o  = '0;
`endif

  assign data_o   = data_q;
  assign delay_o  = delay_q;
  assign valid_o  = valid_q;
  assign direct_o = direct_q;
  assign halted_o = (state_q == ST_HALTED);
  assign err_o    = err_q;

endmodule

// File: tb/tb_marbuf_dispatch.sv
// Scoreboard bench for marbuf_dispatch: directed words, queued
// expectations, independent strobe monitor.
module tb_marbuf_dispatch;

  localparam int NB = 8;

`ifdef MARBUF_DISPATCH_STALL_CNT_EN
  localparam int EXP_STALL = 6;
`else
  localparam int EXP_STALL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          start;
  logic          clr_err;
  logic [NB-1:0] buf_full;
  logic [15:0]   data_o;
  logic [6:0]    delay_o;
  logic [NB-1:0] valid_o;
  logic [NB-1:0] direct_o;
  logic          halted;
  logic          err;
  logic [15:0]   stall_cnt;

  marbuf_dispatch #(.N_BUF(NB), .IDX_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_i      (instr),
    .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready),
    .start_i      (start),
    .clr_err_i    (clr_err),
    .buf_full_i   (buf_full),
    .data_o       (data_o),
    .delay_o      (delay_o),
    .valid_o      (valid_o),
    .direct_o     (direct_o),
    .halted_o     (halted),
    .err_o        (err),
    .stall_cnt_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          dir;
    int          ch;
    logic [15:0] data;
    logic [6:0]  dly;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mk(input logic [1:0] o, input int ch,
                                     input int d, input int dat);
    return {o, 6'(ch), 1'b0, 7'(d), 16'(dat)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [NB-1:0] ev, ed;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && ((valid_o != 0) || (direct_o != 0))) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe valid=%h direct=%h data=%h",
                   valid_o, direct_o, data_o);
        end else begin
          e  = q.pop_front();
          ev = e.dir ? '0 : NB'(1) << e.ch;
          ed = e.dir ? NB'(1) << e.ch : '0;
          if (valid_o !== ev || direct_o !== ed || data_o !== e.data ||
              delay_o !== e.dly || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL strobe got v=%h d=%h data=%h dly=%0d cyc=%0d want v=%h d=%h data=%h dly=%0d cyc=%0d",
                     valid_o, direct_o, data_o, delay_o, cyc,
                     ev, ed, e.data, e.dly, e.cyc);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input bit expect_out,
                      input bit lat);
    exp_t e;
    bit ok;
    int n;
    instr = w;
    instr_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = instr_ready;
      @(posedge clk);
      #1;
      n++;
    end
    instr_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout word=%h", w);
      return;
    end
    if (expect_out) begin
      e.dir  = (w[31:30] == 2'b01);
      e.ch   = int'(w[29:24]);
      e.data = w[15:0];
      e.dly  = w[22:16];
      e.cyc  = lat ? cyc + 1 : -1;
      q.push_back(e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      cycles(1);
      n++;
    end
    cycles(2);
    chk("drain", q.size(), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    start = 1'b0;
    clr_err = 1'b0;
    buf_full = '0;
    cycles(3);
    chk("rst_valid", valid_o, 0);
    chk("rst_direct", direct_o, 0);
    chk("rst_halted", halted, 1);
    chk("rst_ready", instr_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_data", data_o, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b0;
    cycles(1);
    pulse_start();
    chk("run_halted", halted, 0);

    send(mk(2'b00, 2, 5, 16'h1234), 1, 1);
    drain();
    chk("hold_data", data_o, 16'h1234);
    chk("hold_delay", delay_o, 5);

    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(mk(2'b00, 0, 0, i), 1, 0);
      end
      begin
        int n = 0;
        while (!(valid_o[0] && data_o == 16'd4) && n < 100) begin
          cycles(1);
          n++;
        end
        chk("saw_fourth", n < 100, 1);
        buf_full = 8'h01;
        repeat (6) begin
          @(negedge clk);
          chk("stall_ready", instr_ready, 0);
          cycles(1);
        end
        buf_full = '0;
      end
    join
    drain();
    chk("stall_cnt", stall_cnt, EXP_STALL);

    buf_full = '1;
    send(mk(2'b01, 1, 3, 1234), 1, 1);
    drain();
    buf_full = '0;
    chk("direct_no_stall", stall_cnt, EXP_STALL);

    send(mk(2'b10, 0, 0, 0), 0, 0);
    instr = mk(2'b00, 3, 7, 16'hABCD);
    instr_valid = 1'b1;
    cycles(4);
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_ready", instr_ready, 0);
    cycles(1);
    pulse_start();
    send(mk(2'b00, 3, 7, 16'hABCD), 1, 1);
    drain();

    send(mk(2'b11, 0, 0, 0), 0, 0);
    cycles(2);
    chk("err_rsvd", err, 1);
    send(mk(2'b00, 9, 0, 16'h0055), 0, 0);
    cycles(2);
    chk("err_idx", err, 1);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    chk("err_clr", err, 0);
    send(mk(2'b00, 7, 1, 16'h7777), 1, 1);
    send(mk(2'b01, 5, 2, 16'h5555), 1, 1);
    drain();
    chk("err_still_clr", err, 0);

    buf_full = 8'h08;
    send(mk(2'b00, 3, 0, 16'hDEAD), 0, 0);
    cycles(3);
    @(negedge clk);
    chk("pre_rst_ready", instr_ready, 0);
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_direct", direct_o, 0);
    chk("mid_rst_halted", halted, 1);
    chk("mid_rst_stall", stall_cnt, 0);
    cycles(2);
    buf_full = '0;
    rst = 1'b0;
    cycles(1);
    pulse_start();
    send(mk(2'b00, 3, 4, 16'hBEEF), 1, 1);
    drain();
    cycles(5);
    chk("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
